// File: rtl/acc_drain_ppu_pkg.sv
// Shared constants and types for the accumulator drain / requantization block.
// Holds the accumulator width, the number of bank rows drained per start,
// the INT8 saturation bounds and the drain FSM state encoding.
package acc_drain_ppu_pkg;

  localparam int ACC_WIDTH = 32;
  localparam int ARRAY_ROW = 12;
  localparam int ADDR_WIDTH = 4;
  localparam int MULT_WIDTH = 16;
  localparam int SHIFT_WIDTH = 5;
  localparam int OUT_WIDTH = 8;

  localparam int INT8_MIN = -128;
  localparam int INT8_MAX = 127;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_FLUSH = 2'd2
  } drain_state_e;

endpackage

// File: rtl/acc_drain_ppu_requant.sv
// Combinational INT32 -> INT8 requantizer: multiply by an unsigned scale,
// rounding arithmetic right shift (half toward +inf), add a signed zero
// point and saturate. Every intermediate is wide enough that nothing wraps.
module requant_unit
  import acc_drain_ppu_pkg::*;
#(
  parameter int ACC_W   = ACC_WIDTH,
  parameter int MULT_W  = MULT_WIDTH,
  parameter int SHIFT_W = SHIFT_WIDTH,
  parameter int OUT_W   = OUT_WIDTH
) (
  input  logic [ACC_W-1:0]   acc,
  input  logic [MULT_W-1:0]  mult,
  input  logic [SHIFT_W-1:0] shift,
  input  logic [OUT_W-1:0]   zp,
  output logic [OUT_W-1:0]   q
);

  // Product, product plus rounding bias, and value plus zero point.
  localparam int P_W = ACC_W + MULT_W + 1;
  localparam int R_W = P_W + 1;
  localparam int V_W = R_W + 1;

  localparam logic signed [V_W-1:0] V_MAX = V_W'(INT8_MAX);
  localparam logic signed [V_W-1:0] V_MIN = V_W'(INT8_MIN);

  logic signed [P_W-1:0] prod;
  logic signed [R_W-1:0] rnd_bias;
  logic signed [R_W-1:0] biased;
  logic signed [R_W-1:0] shifted;
  logic signed [V_W-1:0] with_zp;

  // Multiply, round-shift, zero point and clamp to the INT8 range.
  always_comb begin
    prod     = $signed(acc) * $signed({1'b0, mult});
    rnd_bias = '0;
    if (shift != '0) begin
      rnd_bias = R_W'(1) << (shift - SHIFT_W'(1));
    end
    biased  = $signed({prod[P_W-1], prod}) + rnd_bias;
    shifted = biased >>> shift;
    with_zp = $signed({shifted[R_W-1], shifted})
            + $signed({{(V_W-OUT_W){zp[OUT_W-1]}}, zp});
    if (with_zp > V_MAX) begin
      q = OUT_W'(INT8_MAX);
    end else if (with_zp < V_MIN) begin
      q = OUT_W'(INT8_MIN);
    end else begin
      q = with_zp[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/acc_drain_ppu.sv
// Drains one column accumulator bank after a tile: walks rows 0..ROWS-1,
// captures the bank's combinational out_acc, requantizes to INT8 and streams
// the results out in address order.
//
// Handshake: a beat transfers on a rising edge where out_valid=1 and
// out_ready=1. Once out_valid rises, out_data/out_last hold steady until
// that transfer; out_valid never depends combinationally on out_ready.
//
// Optional feature: define ACC_CLR_ON_READ_EN to zero each bank row in the
// same cycle it is captured (clear-on-read). Without it bank_wr_en stays 0.
module acc_drain_ppu
  import acc_drain_ppu_pkg::*;
#(
  parameter int ACC_W   = ACC_WIDTH,
  parameter int ROWS    = ARRAY_ROW,
  parameter int ADDR_W  = ADDR_WIDTH,
  parameter int MULT_W  = MULT_WIDTH,
  parameter int SHIFT_W = SHIFT_WIDTH,
  parameter int OUT_W   = OUT_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [MULT_W-1:0]  scale_mult,
  input  logic [SHIFT_W-1:0] scale_shift,
  input  logic [OUT_W-1:0]   zero_point,
  output logic [ADDR_W-1:0]  bank_addr,
  input  logic [ACC_W-1:0]   bank_acc,
  output logic               bank_wr_en,
  output logic               bank_acc_mode,
  output logic [ACC_W-1:0]   bank_wr_data,
  output logic [OUT_W-1:0]   out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_last,
  output logic               busy,
  output logic               done,
  output logic [1:0]         dbg_state
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(ROWS - 1);

  drain_state_e       state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [MULT_W-1:0]  mult_q, mult_d;
  logic [SHIFT_W-1:0] shift_q, shift_d;
  logic [OUT_W-1:0]   zp_q, zp_d;
  logic               s1_valid_q, s1_valid_d;
  logic               s1_last_q, s1_last_d;
  logic [ACC_W-1:0]   s1_acc_q, s1_acc_d;
  logic               out_valid_q, out_valid_d;
  logic               out_last_q, out_last_d;
  logic [OUT_W-1:0]   out_data_q, out_data_d;
  logic               done_q, done_d;

  logic               advance;
  logic               capture;
  logic [OUT_W-1:0]   rq_out;

  requant_unit #(
    .ACC_W   (ACC_W),
    .MULT_W  (MULT_W),
    .SHIFT_W (SHIFT_W),
    .OUT_W   (OUT_W)
  ) u_requant (
    .acc   (s1_acc_q),
    .mult  (mult_q),
    .shift (shift_q),
    .zp    (zp_q),
    .q     (rq_out)
  );

  // FSM next state, address walk, config latch and the two pipeline stages.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    mult_d      = mult_q;
    shift_d     = shift_q;
    zp_d        = zp_q;
    s1_valid_d  = s1_valid_q;
    s1_last_d   = s1_last_q;
    s1_acc_d    = s1_acc_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;
    done_d      = 1'b0;
    capture     = 1'b0;

    // Whole pipeline moves together; it only stalls on a held output beat.
    advance = !out_valid_q || out_ready;

    case (state_q)
      ST_IDLE: begin
        addr_d = '0;
        if (start) begin
          state_d = ST_READ;
          mult_d  = scale_mult;
          shift_d = scale_shift;
          zp_d    = zero_point;
        end
      end
      ST_READ: begin
        if (advance) begin
          capture = 1'b1;
          if (addr_q == LAST_ADDR) begin
            state_d = ST_FLUSH;
          end else begin
            addr_d = addr_q + ADDR_W'(1);
          end
        end
      end
      ST_FLUSH: begin
        // The last beat is the final one in flight, so the pipe is empty
        // once it transfers.
        if (out_valid_q && out_ready && out_last_q) begin
          state_d = ST_IDLE;
          addr_d  = '0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        addr_d  = '0;
      end
    endcase

    if (advance) begin
      s1_valid_d = capture;
      s1_last_d  = capture && (addr_q == LAST_ADDR);
      if (capture) begin
        s1_acc_d = bank_acc;
      end
      out_valid_d = s1_valid_q;
      out_last_d  = s1_valid_q && s1_last_q;
      if (s1_valid_q) begin
        out_data_d = rq_out;
      end
    end
  end

  // State, address, config and pipeline registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      mult_q      <= '0;
      shift_q     <= '0;
      zp_q        <= '0;
      s1_valid_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_acc_q    <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      mult_q      <= mult_d;
      shift_q     <= shift_d;
      zp_q        <= zp_d;
      s1_valid_q  <= s1_valid_d;
      s1_last_q   <= s1_last_d;
      s1_acc_q    <= s1_acc_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
      done_q      <= done_d;
    end
  end

  // Bank write port: optional clear of each row as it is captured.
  always_comb begin
`ifdef ACC_CLR_ON_READ_EN
    bank_wr_en = capture;
`else
    bank_wr_en = 1'b0;
`endif
    bank_acc_mode = 1'b0;
    bank_wr_data  = '0;
  end

  assign bank_addr = addr_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign dbg_state = state_q;

endmodule
